// File: rtl/dmem_mmio.sv
// Data-memory subsystem for the pipelined core's MEM stage.
// Word-addressed data RAM plus a memory-mapped window:
//   0x8000_0000 CYCLE  free-running cycle counter, read-only
//   0x8000_0001 OUTQ   write pushes into the output FIFO, read returns 0
//   0x8000_0002 STATUS read {overflow, full, empty, count}, any write clears overflow
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   en_i, we_i           access enable / write enable
//   addr_i, wdata_i      word address / store data
//   rdata_o              load data, combinational (0 when not loading)
//   out_data_o           FIFO head word (0 when empty)
//   out_valid_o          FIFO not empty
//   out_ready_i          consumer accepts head word
//   overflow_o           sticky: a push to the full FIFO was dropped
module dmem_mmio #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        overflow_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [31:0] AddrCycle  = 32'h8000_0000;
  localparam logic [31:0] AddrOutq   = 32'h8000_0001;
  localparam logic [31:0] AddrStatus = 32'h8000_0002;

  // Address decode
  logic is_ram, is_cycle, is_outq, is_status;
  assign is_ram    = ~addr_i[31];
  assign is_cycle  = (addr_i == AddrCycle);
  assign is_outq   = (addr_i == AddrOutq);
  assign is_status = (addr_i == AddrStatus);

  logic wr_acc;
  assign wr_acc = en_i & we_i;

  // Data RAM, intentionally not reset; upper address bits alias.
  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (wr_acc && is_ram) begin
      mem_q[addr_i[ADDR_W-1:0]] <= wdata_i;
    end
  end

  // Cycle counter
  logic [31:0] cycle_q, cycle_d;
  assign cycle_d = cycle_q + 32'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  // Output FIFO
  logic [31:0]     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, empty, pop, push_req, push_ok, status_wr;

  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign pop       = ~empty & out_ready_i;
  assign push_req  = wr_acc & is_outq;
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign push_ok   = push_req & (~full | pop);
  assign status_wr = wr_acc & is_status;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PtrW'(1);
    end
    if (push_ok) begin
      tail_d = tail_q + PtrW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Set wins over clear should both ever occur together.
  always_comb begin
    overflow_d = overflow_q;
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end else if (status_wr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head word is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      fifo_q[tail_q] <= wdata_i;
    end
  end

  assign out_valid_o = ~empty;
  assign out_data_o  = empty ? 32'd0 : fifo_q[head_q];
  assign overflow_o  = overflow_q;

  // Load path
  logic [31:0] status_word;
  assign status_word = {overflow_q, full, empty, {(29 - CntW){1'b0}}, count_q};

  always_comb begin
    rdata_o = '0;
    if (en_i && !we_i) begin
      if (is_ram) begin
        rdata_o = mem_q[addr_i[ADDR_W-1:0]];
      end else if (is_cycle) begin
        rdata_o = cycle_q;
      end else if (is_status) begin
        rdata_o = status_word;
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

  localparam int unsigned AW = 10;
  localparam int unsigned D  = 4;

  localparam logic [31:0] A_CYC = 32'h8000_0000;
  localparam logic [31:0] A_OUT = 32'h8000_0001;
  localparam logic [31:0] A_ST  = 32'h8000_0002;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i, we_i, out_ready_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o, out_data_o;
  logic        out_valid_o, overflow_o;

  dmem_mmio #(.ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [31:0] mq [$];     // model FIFO contents
  logic [31:0] exp_q [$];  // scoreboard of words expected at the output port
  logic        ov_m;
  logic [31:0] cyc_m;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Expected load data; returns 0 when the value is unknown (unwritten RAM).
  function automatic bit model_rd(input logic e, input logic w, input logic [31:0] a,
                                  output logic [31:0] v);
    int sz;
    v = 32'd0;
    if (!e || w) return 1'b1;
    if (a[31] == 1'b0) begin
      int idx;
      idx = int'(a % (32'd1 << AW));
      if (!ram_m.exists(idx)) return 1'b0;
      v = ram_m[idx];
      return 1'b1;
    end
    sz = mq.size();
    if (a == A_CYC) v = cyc_m;
    else if (a == A_ST) begin
      v = 32'd0;
      if (ov_m)    v = v + 32'h8000_0000;
      if (sz == D) v = v + 32'h4000_0000;
      if (sz == 0) v = v + 32'h2000_0000;
      v = v + 32'(sz);
    end
    return 1'b1;
  endfunction

  // Scoreboard monitor: every completed handshake must deliver the oldest expected word.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_pop: got 0x%08h, expected no word at %0t", out_data_o, $time);
      end else begin
        chk("sb_pop", out_data_o, exp_q.pop_front());
      end
    end
  end

  // One bus cycle; called just after a rising edge.
  task automatic step(input logic e, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic r);
    bit          known, pop, push_req, push_ok;
    logic [31:0] ev, hd;
    en_i = e; we_i = w; addr_i = a; wdata_i = d; out_ready_i = r;
    known = model_rd(e, w, a, ev);
    @(negedge clk_i);
    if (known) chk("rdata", rdata_o, ev);
    hd = (mq.size() != 0) ? mq[0] : 32'd0;
    chk("out_valid", {31'd0, out_valid_o}, {31'd0, mq.size() != 0});
    chk("out_data", out_data_o, hd);
    chk("overflow", {31'd0, overflow_o}, {31'd0, ov_m});
    pop      = (mq.size() != 0) && r;
    push_req = e && w && (a == A_OUT);
    push_ok  = push_req && ((mq.size() < D) || pop);
    @(posedge clk_i);
    #1;
    if (pop) void'(mq.pop_front());
    if (push_ok) begin
      mq.push_back(d);
      exp_q.push_back(d);
    end
    if (push_req && !push_ok) ov_m = 1'b1;
    else if (e && w && a == A_ST) ov_m = 1'b0;
    if (e && w && !a[31]) ram_m[int'(a % (32'd1 << AW))] = d;
    cyc_m = cyc_m + 32'd1;
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, 32'd0, 32'd0, r);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    ram_m.delete();
    ov_m  = 1'b0;
    cyc_m = 32'd0;
  endtask

  initial begin
    logic [31:0] a, d, lo;
    int          op;
    rst_ni = 1'b0;
    en_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; out_ready_i = 1'b0;
    model_reset();
    #2;
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_out_data", out_data_o, 32'd0);
    chk("rst_overflow", {31'd0, overflow_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Cycle counter: 10 idle cycles then read
    for (int i = 0; i < 10; i++) idle(1'b0);
    step(1'b1, 1'b0, A_CYC, 32'd0, 1'b0);
    // RAM round trip and alias
    step(1'b1, 1'b1, 32'h5, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 1'b0, 32'h5, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'h405, 32'd0, 1'b0);
    // FIFO ordering
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, A_OUT, 32'(i), 1'b0);
    step(1'b1, 1'b0, A_ST, 32'd0, 1'b0);
    step(1'b1, 1'b0, A_OUT, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    // Overflow: five pushes into depth four
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, A_OUT, 32'h100 + 32'(i), 1'b0);
    step(1'b1, 1'b0, A_ST, 32'd0, 1'b0);
    step(1'b1, 1'b1, A_ST, 32'd0, 1'b0);
    step(1'b1, 1'b0, A_ST, 32'd0, 1'b0);
    // Full with simultaneous push and pop
    step(1'b1, 1'b1, A_OUT, 32'hE, 1'b1);
    step(1'b1, 1'b0, A_ST, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    // Counter wrap
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1 release dut.cycle_q;
    cyc_m = 32'hFFFF_FFFF;
    step(1'b1, 1'b0, A_CYC, 32'd0, 1'b0);
    step(1'b1, 1'b0, A_CYC, 32'd0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      op = int'($urandom_range(0, 11));
      d  = $urandom();
      lo = $urandom_range(0, 15);
      a  = (($urandom() & 32'h7FFF_FFFF) & ~32'h3FF) | lo;
      case (op)
        0, 1:    step(1'b1, 1'b1, a, d, $urandom_range(0, 2) != 0);
        2, 3:    step(1'b1, 1'b0, a, d, $urandom_range(0, 2) != 0);
        4, 5, 6: step(1'b1, 1'b1, A_OUT, d, $urandom_range(0, 2) == 0);
        7:       step(1'b1, 1'b0, A_ST, d, $urandom_range(0, 1) != 0);
        8:       step(1'b1, ($urandom_range(0, 7) == 0), A_ST, d, 1'b1);
        9:       step(1'b1, $urandom_range(0, 1) != 0, A_CYC + 32'($urandom_range(0, 1)), d,
                      $urandom_range(0, 1) != 0);
        10:      step(1'b1, $urandom_range(0, 1) != 0, A_ST + 32'($urandom_range(1, 5000)), d,
                      $urandom_range(0, 1) != 0);
        default: step(1'b0, $urandom_range(0, 1) != 0, A_OUT, d, $urandom_range(0, 1) != 0);
      endcase
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Async reset mid-stream with two words queued and overflow set
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, A_OUT, 32'h200 + 32'(i), 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("arst_out_data", out_data_o, 32'd0);
    chk("arst_overflow", {31'd0, overflow_o}, 32'd0);
    model_reset();
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    step(1'b1, 1'b0, A_CYC, 32'd0, 1'b0);
    step(1'b1, 1'b0, A_ST, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory subsystem for the pipelined RISC-V core. It sits directly downstream of the datapath's MEM stage. It consumes the data-memory enable, write-enable, word address (ALU result) and store data driven from the EX/MEM registers, and returns load data combinationally for capture into the MEM/WB register. Besides a word-addressed data RAM, it exposes a memory-mapped window holding a free-running cycle counter and a buffered output port with a valid/ready handshake.

## Interface
- ADDR_W, 10: RAM holds 2^ADDR_W 32-bit words.
- FIFO_DEPTH, 4: output FIFO depth; a power of two, at least 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- en  in  1  access enable (datamem_en).
- we  in  1  write enable (datamem_we); only meaningful while en=1.
- addr  in  32  word address (result_EX).
- wdata  in  32  store data (rs2_EX).
- rdata  out  32  load data, combinational.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream consumer accepts the head word.
- overflow  out  1  sticky flag: a store to the FIFO was dropped.

## Operation
- Address decode (word addresses):
  - addr[31]=0: RAM, indexed by addr[ADDR_W-1:0]. Bits addr[30:ADDR_W] are ignored, so the RAM aliases.
  - 0x8000_0000: CYCLE, read-only.
  - 0x8000_0001: OUTQ, write pushes into the FIFO; a read returns 0.
  - 0x8000_0002: STATUS.
    - Read returns {overflow (bit 31), full (bit 30), empty (bit 29), count (low bits)}; all other bits are 0.
    - Any write clears overflow.
  - Any other address with addr[31]=1: reads return 0, writes are ignored.
- Loads (en=1, we=0): rdata is the decoded word, combinational in the same cycle. rdata=0 whenever en=0 or we=1.
- RAM stores (en=1, we=1, RAM region): the word is written on the rising edge.
  - The RAM array is not reset; its contents after reset are undefined.
- CYCLE: 32-bit counter.
  - Reset value 0.
  - Increments every cycle and wraps from 0xFFFF_FFFF to 0.
  - A read returns the value before that cycle's increment.
- FIFO:
  - Circular buffer with head/tail pointers and a count of width clog2(FIFO_DEPTH)+1.
  - pop = out_valid && out_ready.
  - push request = en && we && addr==OUTQ.
  - Push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle (full with simultaneous pop: both happen, count unchanged).
  - A rejected push leaves the FIFO unchanged and sets overflow.
  - out_valid = (count!=0).
  - out_data = head word when non-empty, 0 when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: sticky.
  - Reset value 0.
  - Set when a push is rejected.
  - Cleared by a STATUS write.
  - A set and a clear in the same cycle cannot coincide (a single access port); if a future port is added, set takes precedence.
- Reset mid-operation: FIFO empties immediately, count=0, out_valid=0, out_data=0, overflow=0, CYCLE=0. RAM contents are retained but undefined.

## Timing
- Output values during and immediately after reset: rdata=0 (while en=0), out_valid=0, out_data=0, overflow=0.
- Load latency: 0 cycles (combinational). The datapath samples rdata at the next edge.
- A store becomes visible to a load one cycle later. A load to the same RAM word in the same cycle as a store returns the old data.
- Push to out_valid: 1 cycle. A STATUS read in the push cycle shows the pre-push count.
- Handshake rules:
  - out_data and out_valid stay stable until a pop.
  - out_ready may be asserted at any time without effect while empty.
  - No combinational path exists from out_ready to out_valid.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- RAM round trip: store 0xDEAD_BEEF to addr 0x5, then load 0x5 on the next cycle -> rdata=0xDEAD_BEEF. Load addr 0x405 with ADDR_W=10 -> same value (alias).
- Cycle counter: release reset, idle 10 cycles, read CYCLE -> 10. Force the counter to 0xFFFF_FFFF -> it reads 0 one cycle later.
- FIFO ordering: push 1, 2, 3 with out_ready=0 -> out_valid=1, out_data=1, STATUS count=3. Assert out_ready -> pops 1, 2, 3 on consecutive edges, then out_valid=0 and out_data=0.
- Overflow: with out_ready=0, push 5 words into depth 4 -> the 5th is dropped, overflow=1, full=1. Write STATUS -> overflow=0 next cycle.
- Full with simultaneous push and pop: FIFO full holding A,B,C,D; push E with out_ready=1 -> A popped, E accepted, count stays 4, overflow stays 0.
- Async reset mid-stream: FIFO holding 2 words, drop rst low between edges -> out_valid=0, out_data=0 and overflow=0 immediately, before any clock edge.
